// File: rtl/pixel_window_scanner.sv
// pixel_window_scanner: holds the three most recent pixel rows and scans them left to right,
// emitting NUM_BLK 3x3 windows per beat over a valid/ready interface. Window elements are
// either raw pixels or signed differences from the window centre.
module pixel_window_scanner #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned OUT_W   = 12,
  parameter int unsigned ROW_PIX = 70,
  parameter int unsigned NUM_BLK = 4,
  parameter int unsigned COL_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [ROW_PIX*PIX_W-1:0]     pixel_in,
  input  logic                         mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [COL_W-1:0]             out_col,
  output logic [NUM_BLK-1:0]           out_mask,
  output logic [NUM_BLK*9*OUT_W-1:0]   block_out
);

  localparam int unsigned NumWin = ROW_PIX - 2;
  localparam int unsigned RowW   = ROW_PIX * PIX_W;

  typedef enum logic {StIdle, StScan} state_e;

  state_e           state_q, state_d;
  logic [RowW-1:0]  r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             mode_q, mode_d;

  logic             row_acc, beat_acc, last_beat;
  logic [1:0]       cnt_next;
  logic [RowW-1:0]  rows [3];

  // Handshake decode and the last-beat condition for the current column.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StScan);
    row_acc   = in_valid & in_ready;
    beat_acc  = out_valid & out_ready;
    last_beat = (32'(col_q) + NUM_BLK >= NumWin);
    // A frame-start row restarts the fill; otherwise the count saturates at three rows.
    cnt_next  = in_sof ? 2'd1 : ((cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1);
  end

  // Next-state: row shifting, fill count, scan entry/exit and column stepping.
  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    mode_d  = mode_q;
    if (row_acc) begin
      r0_d  = r1_q;
      r1_d  = r2_q;
      r2_d  = pixel_in;
      cnt_d = cnt_next;
      if (cnt_next == 2'd3) begin
        state_d = StScan;
        col_d   = '0;
        mode_d  = mode;
      end
    end
    if (beat_acc) begin
      if (last_beat) begin
        state_d = StIdle;
        col_d   = '0;
      end else begin
        col_d = col_q + COL_W'(NUM_BLK);
      end
    end
  end

  // State registers with asynchronous reset; a reset mid-scan abandons the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
    end
  end

  // Window assembly straight from the row registers; masked blocks read column 0 and output 0.
  always_comb begin
    rows[0]   = r0_q;
    rows[1]   = r1_q;
    rows[2]   = r2_q;
    out_last  = out_valid & last_beat;
    out_col   = col_q;
    out_mask  = '0;
    block_out = '0;
    for (int unsigned k = 0; k < NUM_BLK; k++) begin
      logic             win_ok;
      int unsigned      base;
      logic [OUT_W-1:0] ctr_ext;
      win_ok      = out_valid && (32'(col_q) + k < NumWin);
      out_mask[k] = win_ok;
      base        = win_ok ? 32'(col_q) + k : 32'd0;
      ctr_ext     = {{(OUT_W-PIX_W){1'b0}}, r1_q[(base+1)*PIX_W +: PIX_W]};
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          logic [OUT_W-1:0] pix_ext;
          pix_ext = {{(OUT_W-PIX_W){1'b0}}, rows[r][(base+c)*PIX_W +: PIX_W]};
          if (win_ok) begin
            block_out[(k*9+r*3+c)*OUT_W +: OUT_W] = mode_q ? (pix_ext - ctr_ext) : pix_ext;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_scanner.sv
// Self-checking bench for pixel_window_scanner: a 70-pixel and an 11-pixel instance checked
// against an array-based window model, directed table cases and randomized rows/backpressure.
module tb_pixel_window_scanner;
  localparam int PIX_W   = 8;
  localparam int OUT_W   = 12;
  localparam int NUM_BLK = 4;
  localparam int COL_W   = 7;
  localparam int RP_A    = 70;
  localparam int RP_B    = 11;
  localparam int BW      = NUM_BLK * 9 * OUT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_sof, mode, out_ready;
  logic iv_a, ir_a, ov_a, ol_a;
  logic [COL_W-1:0] oc_a;
  logic [NUM_BLK-1:0] om_a;
  logic [BW-1:0] bo_a;
  logic [RP_A*PIX_W-1:0] px_a;
  logic iv_b, ir_b, ov_b, ol_b;
  logic [COL_W-1:0] oc_b;
  logic [NUM_BLK-1:0] om_b;
  logic [BW-1:0] bo_b;
  logic [RP_B*PIX_W-1:0] px_b;

  pixel_window_scanner #(.PIX_W(PIX_W), .OUT_W(OUT_W), .ROW_PIX(RP_A), .NUM_BLK(NUM_BLK),
                         .COL_W(COL_W)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_sof(in_sof), .pixel_in(px_a),
    .mode(mode), .out_valid(ov_a), .out_ready(out_ready), .out_last(ol_a), .out_col(oc_a),
    .out_mask(om_a), .block_out(bo_a));

  pixel_window_scanner #(.PIX_W(PIX_W), .OUT_W(OUT_W), .ROW_PIX(RP_B), .NUM_BLK(NUM_BLK),
                         .COL_W(COL_W)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_sof(in_sof), .pixel_in(px_b),
    .mode(mode), .out_valid(ov_b), .out_ready(out_ready), .out_last(ol_b), .out_col(oc_b),
    .out_mask(om_b), .block_out(bo_b));

  // Reference model: the three stored rows per instance, fill count and scan mode.
  int  mrow [2][3][RP_A];
  int  mcnt [2];
  bit  mmode [2];
  int  cur_row [RP_A];
  int  checks = 0;
  int  errors = 0;

  function automatic int rp(input bit s);
    return s ? RP_B : RP_A;
  endfunction

  function automatic logic get_valid(input bit s);  return s ? ov_b : ov_a; endfunction
  function automatic logic get_ready(input bit s);  return s ? ir_b : ir_a; endfunction
  function automatic logic get_last(input bit s);   return s ? ol_b : ol_a; endfunction
  function automatic logic [COL_W-1:0] get_col(input bit s);  return s ? oc_b : oc_a; endfunction
  function automatic logic [NUM_BLK-1:0] get_mask(input bit s); return s ? om_b : om_a; endfunction
  function automatic logic [BW-1:0] get_block(input bit s);   return s ? bo_b : bo_a; endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected windows for a beat starting at column col, computed from the model rows.
  function automatic logic [BW-1:0] exp_block(input bit s, input int col);
    logic [BW-1:0] v = '0;
    int nw = rp(s) - 2;
    for (int k = 0; k < NUM_BLK; k++) begin
      if (col + k < nw) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            int pix = mrow[s][r][col+k+c];
            int d = mmode[s] ? pix - mrow[s][1][col+k+1] : pix;
            v[(k*9+r*3+c)*OUT_W +: OUT_W] = d[OUT_W-1:0];
          end
        end
      end
    end
    return v;
  endfunction

  task automatic send_row(input bit s, input bit sof);
    for (int p = 0; p < rp(s); p++) begin
      if (s) px_b[p*PIX_W +: PIX_W] = 8'(cur_row[p]);
      else   px_a[p*PIX_W +: PIX_W] = 8'(cur_row[p]);
    end
    in_sof = sof;
    chk("in_ready_idle", get_ready(s), 1);
    if (s) iv_b = 1'b1; else iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0; in_sof = 1'b0;
    for (int p = 0; p < RP_A; p++) begin
      mrow[s][0][p] = mrow[s][1][p];
      mrow[s][1][p] = mrow[s][2][p];
      mrow[s][2][p] = cur_row[p] & 255;
    end
    mcnt[s] = sof ? 1 : (mcnt[s] < 3 ? mcnt[s] + 1 : 3);
    if (mcnt[s] == 3) mmode[s] = mode;
    chk("start_latency", get_valid(s), (mcnt[s] == 3) ? 1 : 0);
  endtask

  // Three rows with pixel(n, p) = (base + 16n + p) & 0xFF, the first flagged as frame start.
  task automatic rows3(input bit s, input int base, input bit md);
    mode = md;
    for (int n = 0; n < 3; n++) begin
      for (int p = 0; p < RP_A; p++) cur_row[p] = (base + n * 16 + p) & 255;
      send_row(s, n == 0);
    end
  endtask

  task automatic rand_row();
    for (int p = 0; p < RP_A; p++) cur_row[p] = int'($urandom_range(0, 255));
  endtask

  // Consume one full scan; stall_beat gets 5 stall cycles, rnd adds 0-2 random stalls per beat.
  task automatic scan(input bit s, input int stall_beat, input bit rnd, output int nbeats,
                      output logic [BW-1:0] first_blk, output logic [NUM_BLK-1:0] last_mask);
    int nw = rp(s) - 2;
    nbeats = 0;
    first_blk = '0;
    last_mask = '0;
    for (int b = 0; b < 40; b++) begin
      int col = b * NUM_BLK;
      logic [BW-1:0] eb = exp_block(s, col);
      logic [NUM_BLK-1:0] em = '0;
      bit el = (col + NUM_BLK >= nw);
      int stalls = (b == stall_beat) ? 5 : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k < NUM_BLK; k++) em[k] = (col + k < nw);
      for (int i = 0; i < stalls; i++) begin
        out_ready = 1'b0;
        mode = ~mode;
        @(posedge clk); #1;
        chk("stall_valid", get_valid(s), 1);
        chk("stall_col", get_col(s), col);
        chk("stall_block", get_block(s), eb);
      end
      out_ready = 1'b1;
      chk("beat_valid", get_valid(s), 1);
      chk("beat_col", get_col(s), col);
      chk("beat_mask", get_mask(s), em);
      chk("beat_last", get_last(s), el);
      chk("beat_block", get_block(s), eb);
      if (b == 0) first_blk = get_block(s);
      last_mask = get_mask(s);
      nbeats++;
      @(posedge clk); #1;
      if (el) break;
    end
    chk("scan_done_valid", get_valid(s), 0);
    chk("scan_done_ready", get_ready(s), 1);
  endtask

  typedef struct {
    bit s;
    bit md;
    int base;
    int beats;
    logic [3:0] lmask;
    logic [11:0] e0, e4, e8;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    logic [BW-1:0] fb;
    logic [NUM_BLK-1:0] lm;

    tbl[0] = '{s: 0, md: 0, base: 0,   beats: 17, lmask: 4'hF, e0: 12'h000, e4: 12'h011, e8: 12'h022};
    tbl[1] = '{s: 1, md: 0, base: 0,   beats: 3,  lmask: 4'h1, e0: 12'h000, e4: 12'h011, e8: 12'h022};
    tbl[2] = '{s: 0, md: 1, base: 240, beats: 17, lmask: 4'hF, e0: 12'h0EF, e4: 12'h000, e8: 12'h011};
    tbl[3] = '{s: 1, md: 0, base: 240, beats: 3,  lmask: 4'h1, e0: 12'h0F0, e4: 12'h001, e8: 12'h012};

    rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; in_sof = 1'b0; mode = 1'b0; out_ready = 1'b1;
    px_a = '0; px_b = '0;
    for (int s = 0; s < 2; s++) begin
      mcnt[s] = 0; mmode[s] = 0;
      for (int r = 0; r < 3; r++) for (int p = 0; p < RP_A; p++) mrow[s][r][p] = 0;
    end
    #1;
    chk("rst_in_ready", ir_a, 1);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_last", ol_a, 0);
    chk("rst_out_col", oc_a, 0);
    chk("rst_out_mask", om_a, 0);
    chk("rst_block_out", bo_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table: full scans on both widths, raw and difference modes.
    for (int i = 0; i < 4; i++) begin
      rows3(tbl[i].s, tbl[i].base, tbl[i].md);
      scan(tbl[i].s, (i == 0) ? 2 : -1, 1'b0, nb, fb, lm);
      chk("tbl_beats", nb, tbl[i].beats);
      chk("tbl_last_mask", lm, tbl[i].lmask);
      chk("tbl_e0", fb[0 +: OUT_W], tbl[i].e0);
      chk("tbl_e4", fb[4*OUT_W +: OUT_W], tbl[i].e4);
      chk("tbl_e8", fb[8*OUT_W +: OUT_W], tbl[i].e8);
    end

    // Difference mode with chosen corner pixels around the first window.
    mode = 1'b1;
    rand_row(); cur_row[0] = 90;  send_row(0, 1);
    rand_row(); cur_row[1] = 100; send_row(0, 0);
    rand_row(); cur_row[2] = 255; send_row(0, 0);
    scan(0, -1, 1'b1, nb, fb, lm);
    chk("diff_e0", fb[0 +: OUT_W], 12'hFF6);
    chk("diff_e4", fb[4*OUT_W +: OUT_W], 12'h000);
    chk("diff_e8", fb[8*OUT_W +: OUT_W], 12'h09B);

    // Asynchronous reset in the middle of a scan.
    rows3(0, 5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", ir_a, 1);
    chk("mid_rst_out_valid", ov_a, 0);
    chk("mid_rst_out_last", ol_a, 0);
    chk("mid_rst_out_col", oc_a, 0);
    chk("mid_rst_out_mask", om_a, 0);
    chk("mid_rst_block_out", bo_a, 0);
    for (int s = 0; s < 2; s++) begin
      mcnt[s] = 0;
      for (int r = 0; r < 3; r++) for (int p = 0; p < RP_A; p++) mrow[s][r][p] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", ov_a, 0);
    mode = 1'b0;
    rand_row(); send_row(0, 0);
    rand_row(); send_row(0, 0);
    rand_row(); send_row(0, 0);
    scan(0, -1, 1'b1, nb, fb, lm);
    chk("post_rst_beats", nb, 17);

    // Frame start mid-fill restarts the count; then vertical stride 1.
    rand_row(); send_row(0, 1);
    rand_row(); send_row(0, 0);
    rand_row(); send_row(0, 1);
    rand_row(); send_row(0, 0);
    mode = 1'b1;
    rand_row(); send_row(0, 0);
    scan(0, -1, 1'b0, nb, fb, lm);
    chk("sof_scan_beats", nb, 17);
    mode = 1'b0;
    rand_row(); send_row(0, 0);
    scan(0, -1, 1'b1, nb, fb, lm);
    chk("stride_scan_beats", nb, 17);

    // Randomized rows, frame starts, modes and backpressure on both instances.
    for (int it = 0; it < 12; it++) begin
      bit s = 1'($urandom_range(0, 1));
      rand_row();
      mode = 1'($urandom_range(0, 1));
      send_row(s, $urandom_range(0, 3) == 0);
      if (mcnt[s] == 3) scan(s, -1, 1'b1, nb, fb, lm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
